// File: rtl/instr_fetch_unit.sv
`timescale 1ns/1ps
// Fetch stage: fetch PC, sync-read imem request, 2-entry instruction FIFO.
// `define IFU_PERF_CNT_EN adds saturating perf_fetched / perf_bubbles counters.
module instr_fetch_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int IMEM_AW = 8
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_rdata,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [XLEN-1:0]    instr,
  output logic [XLEN-1:0]    instr_pc,
  output logic [XLEN-1:0]    pc_plus4
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_bubbles
`endif
);

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic [XLEN-1:0] fpc;
  logic [XLEN-1:0] inflight_pc;
  logic [XLEN-1:0] target;
  logic            inflight;
  logic            kill;
  logic [1:0]      count;
  entry_t          e0;
  entry_t          e1;
  entry_t          new_e;
  logic            pop;
  logic            push;
  logic [2:0]      occ;

  assign instr_valid = (count != 2'd0);
  assign pop = instr_valid & instr_ready;
  // A redirect in the arrival cycle discards the response as well.
  assign push = inflight & ~kill & ~redirect_valid;
  assign occ = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign imem_en = rst & ~redirect_valid & (occ < 3'd2);
  assign imem_addr = fpc[IMEM_AW+1:2];
  assign target = redirect_pc & ~XLEN'(3);

  assign new_e = '{instr: imem_rdata, pc: inflight_pc};
  assign instr = e0.instr;
  assign instr_pc = e0.pc;
  assign pc_plus4 = e0.pc + XLEN'(4);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc <= RESET_PC;
      inflight <= 1'b0;
      inflight_pc <= '0;
      kill <= 1'b0;
      count <= 2'd0;
      e0 <= '0;
      e1 <= '0;
    end else begin
      kill <= redirect_valid;
      inflight <= imem_en;
      if (imem_en) begin
        inflight_pc <= fpc;
        fpc <= fpc + XLEN'(4);
      end
      if (redirect_valid) begin
        fpc <= target;
        count <= 2'd0;
      end else begin
        unique case ({push, pop})
          2'b10: begin
            if (count == 2'd0) e0 <= new_e;
            else e1 <= new_e;
          end
          2'b01: e0 <= e1;
          2'b11: begin
            if (count == 2'd1) begin
              e0 <= new_e;
            end else begin
              e0 <= e1;
              e1 <= new_e;
            end
          end
          default: ;
        endcase
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (pop && perf_fetched != 32'hFFFF_FFFF)
        perf_fetched <= perf_fetched + 32'd1;
      if (instr_ready && !instr_valid && perf_bubbles != 32'hFFFF_FFFF)
        perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule
